alu_4bit: RTL and testbench
===========================

Name: alu_4bit

Overview:
- Registered 4-bit combinational-op ALU with eight operations selected by a 3-bit opcode.
- Operands and opcode are sampled on a valid strobe. The result and status flags are registered with 1-cycle latency.
- Leaf arithmetic block for small datapaths and demo cores. It has no internal state beyond the output register.

Parameters:
- WIDTH, 4, operand/result width in bits; legal values ≥2, and all numbers below assume 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- select  input  3  opcode
- in_valid  input  1  sample a/b/select this cycle
- result  output  WIDTH  registered result
- out_valid  output  1  result/flags updated on the previous edge
- carry  output  1  carry/borrow/shifted-out bit (ALU_FLAGS_EN only)
- zero  output  1  result==0 (ALU_FLAGS_EN only)
- overflow  output  1  signed overflow for add/sub (ALU_FLAGS_EN only)

Behaviour:
- Reset: rst is synchronous and active-high. On a rising clk edge with rst=1: result=0, out_valid=0, carry=0, zero=0, overflow=0. rst has priority over in_valid.
- Latency: in_valid=1 at edge N registers the op result at edge N, so it is visible after N. out_valid=1 for exactly the cycle following each accepted input.
- Hold: in_valid=0 leaves result and flags unchanged and drives out_valid to 0 at the next edge.
- Back-to-back operation: consecutive in_valid cycles are accepted every cycle. There is no backpressure.
- Opcodes (arithmetic wraps modulo 2^WIDTH, all unsigned unless noted):
  - 000 ADD: a+b; carry=bit WIDTH of the full sum.
  - 001 SUB: a-b; carry=1 when a<b (borrow).
  - 010 AND: a&b; carry=0.
  - 011 OR: a|b; carry=0.
  - 100 XOR: a^b; carry=0.
  - 101 NOT: ~a, b ignored; carry=0.
  - 110 SHR: a>>1 logical, MSB filled with 0; carry=a[0].
  - 111 SHL: a<<1, LSB filled with 0; carry=a[WIDTH-1].
- Flags:
  - zero reflects the registered result.
  - overflow=1 only for ADD when a and b have equal MSBs differing from the result MSB. For SUB it is 1 when a and b MSBs differ and the result MSB differs from a's MSB. It is 0 for all other opcodes.
- X/unknown select is not required to be handled. All 8 codes are defined, so there is no illegal-opcode case.
- Reset asserted mid-stream discards the input sampled that cycle.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: carry, zero and overflow are computed and registered as in Behaviour.
- Undefined: the flag ports still exist but are tied constant 0, and no flag logic is synthesized. result and out_valid are identical in both builds.

Test Plan:
- Reset then ADD: rst=1 for 2 cycles → result=0000, out_valid=0. Then a=3, b=5, select=000, in_valid=1 → next cycle result=1000, out_valid=1, carry=0, overflow=1, zero=0.
- SUB and borrow: a=5, b=2, select=001 → result=0011, carry=0. Then a=2, b=5 → result=1101, carry=1.
- Logic ops with a=5, b=2:
  - AND → 0000, zero=1
  - OR → 0111
  - XOR → 0111
  - NOT → 1010
- Shifts with a=5:
  - SHR → 0010, carry=1
  - SHL → 1010, carry=0
  - a=1000 SHL → 0000, carry=1, zero=1
- Hold and valid: ADD a=15, b=1 (result 0000, carry=1), then in_valid=0 for 3 cycles → result and flags unchanged, out_valid=0. Back-to-back valid each cycle → out_valid stays 1 and result tracks each op 1 cycle later.
- Reset mid-stream: in_valid=1 with rst=1 at the same edge → result=0, out_valid=0. With ALU_FLAGS_EN undefined, rerun the ADD case → carry/zero/overflow stay 0 and result is still 1000.

Source files
------------

// File: rtl/alu_4bit.sv
// Registered WIDTH-bit ALU with eight opcodes and a 1-cycle result latency.
// Define ALU_FLAGS_EN to build the carry/zero/overflow flags; otherwise the flag ports are tied to 0.
module alu_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       select,
   input  logic             in_valid,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   output logic             carry,
   output logic             zero,
   output logic             overflow
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHR = 3'b110,
      OP_SHL = 3'b111
   } op_e;

   op_e              op;
   logic [WIDTH-1:0] res_nx;
   logic [WIDTH-1:0] result_d, result_q;
   logic             out_valid_d, out_valid_q;

   assign op = op_e'(select);

   always_comb begin
      res_nx = '0;
      case (op)
         OP_ADD: res_nx = a + b;
         OP_SUB: res_nx = a - b;
         OP_AND: res_nx = a & b;
         OP_OR:  res_nx = a | b;
         OP_XOR: res_nx = a ^ b;
         OP_NOT: res_nx = ~a;
         OP_SHR: res_nx = a >> 1;
         OP_SHL: res_nx = a << 1;
         default: res_nx = '0;
      endcase
   end

   always_comb begin
      result_d    = in_valid ? res_nx : result_q;
      out_valid_d = in_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign result    = result_q;
   assign out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
   logic carry_nx, ovf_nx;
   logic carry_d, carry_q;
   logic zero_d, zero_q;
   logic overflow_d, overflow_q;

   // Carry out of a wrapped add shows up as the sum falling below an operand.
   always_comb begin
      carry_nx = 1'b0;
      ovf_nx   = 1'b0;
      case (op)
         OP_ADD: begin
            carry_nx = (res_nx < a);
            ovf_nx   = (a[WIDTH-1] == b[WIDTH-1]) && (res_nx[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            carry_nx = (a < b);
            ovf_nx   = (a[WIDTH-1] != b[WIDTH-1]) && (res_nx[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SHR:  carry_nx = a[0];
         OP_SHL:  carry_nx = a[WIDTH-1];
         default: carry_nx = 1'b0;
      endcase
   end

   always_comb begin
      carry_d    = in_valid ? carry_nx        : carry_q;
      zero_d     = in_valid ? (res_nx == '0)  : zero_q;
      overflow_d = in_valid ? ovf_nx          : overflow_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         carry_q    <= 1'b0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         carry_q    <= carry_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
      end
   end

   assign carry    = carry_q;
   assign zero     = zero_q;
   assign overflow = overflow_q;
`else
   assign carry    = 1'b0;
   assign zero     = 1'b0;
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: the driver queues the expected post-edge state for every
// cycle, and a monitor pops and compares it just after each rising edge.
module tb_alu_4bit;

   logic       clk;
   logic       rst;
   logic [3:0] a, b;
   logic [2:0] select;
   logic       in_valid;
   logic [3:0] result;
   logic       out_valid, carry, zero, overflow;

   alu_4bit #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .select   (select),
      .in_valid (in_valid),
      .result   (result),
      .out_valid(out_valid),
      .carry    (carry),
      .zero     (zero),
      .overflow (overflow)
   );

   typedef struct packed {
      logic [3:0] res;
      logic       ov;
      logic       c;
      logic       z;
      logic       o;
   } exp_t;

   exp_t q[$];
   exp_t last_exp;
   int   pass_cnt;
   int   total_cnt;
   bit   armed;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flags are only expected when the flag logic is built in.
   function automatic exp_t mk(input logic [3:0] r, input logic c, input logic z, input logic o);
      exp_t e;
      e.res = r;
      e.ov  = 1'b1;
`ifdef ALU_FLAGS_EN
      e.c = c; e.z = z; e.o = o;
`else
      e.c = 1'b0; e.z = 1'b0; e.o = 1'b0;
      if (c || z || o) e.ov = 1'b1;
`endif
      return e;
   endfunction

   task automatic drive(input logic r, input logic iv, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic [2:0] sel, input logic [3:0] er,
                        input logic ec, input logic ez, input logic eo);
      exp_t e;
      @(negedge clk);
      rst = r; in_valid = iv; a = ta; b = tb_; select = sel;
      if (r)       e = '0;
      else if (iv) e = mk(er, ec, ez, eo);
      else begin
         e    = last_exp;
         e.ov = 1'b0;
      end
      last_exp = e;
      q.push_back(e);
      armed = 1'b1;
   endtask

   always begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         total_cnt++;
         if (result === e.res && out_valid === e.ov && carry === e.c &&
             zero === e.z && overflow === e.o)
            pass_cnt++;
         else
            $display("FAIL cycle_check t=%0t: got res=%b ov=%b c=%b z=%b o=%b, expected res=%b ov=%b c=%b z=%b o=%b",
                     $time, result, out_valid, carry, zero, overflow, e.res, e.ov, e.c, e.z, e.o);
      end else if (armed && out_valid !== 1'b0) begin
         total_cnt++;
         $display("FAIL spurious_valid t=%0t: got out_valid=%b, expected 0", $time, out_valid);
      end
   end

   initial begin
      pass_cnt = 0; total_cnt = 0; armed = 1'b0; last_exp = '0;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; select = '0;

      //     rst  iv   a      b      sel     res      c  z  o
      drive(1, 0, 4'd0,  4'd0,  3'b000, 4'b0000, 0, 0, 0);
      drive(1, 0, 4'd0,  4'd0,  3'b000, 4'b0000, 0, 0, 0);
      drive(0, 1, 4'd3,  4'd5,  3'b000, 4'b1000, 0, 0, 1);
      drive(0, 1, 4'd5,  4'd2,  3'b001, 4'b0011, 0, 0, 0);
      drive(0, 1, 4'd2,  4'd5,  3'b001, 4'b1101, 1, 0, 0);
      drive(0, 1, 4'd5,  4'd2,  3'b010, 4'b0000, 0, 1, 0);
      drive(0, 1, 4'd5,  4'd2,  3'b011, 4'b0111, 0, 0, 0);
      drive(0, 1, 4'd5,  4'd2,  3'b100, 4'b0111, 0, 0, 0);
      drive(0, 1, 4'd5,  4'd2,  3'b101, 4'b1010, 0, 0, 0);
      drive(0, 1, 4'd5,  4'd0,  3'b110, 4'b0010, 1, 0, 0);
      drive(0, 1, 4'd5,  4'd0,  3'b111, 4'b1010, 0, 0, 0);
      drive(0, 1, 4'd8,  4'd0,  3'b111, 4'b0000, 1, 1, 0);
      drive(0, 1, 4'd15, 4'd1,  3'b000, 4'b0000, 1, 1, 0);
      drive(0, 0, 4'd9,  4'd9,  3'b000, 4'b0000, 0, 0, 0);
      drive(0, 0, 4'd3,  4'd4,  3'b001, 4'b0000, 0, 0, 0);
      drive(0, 0, 4'd7,  4'd7,  3'b101, 4'b0000, 0, 0, 0);
      drive(0, 1, 4'd7,  4'd1,  3'b000, 4'b1000, 0, 0, 1);
      drive(0, 1, 4'd8,  4'd1,  3'b001, 4'b0111, 0, 0, 1);
      drive(0, 1, 4'd15, 4'd15, 3'b100, 4'b0000, 0, 1, 0);
      drive(0, 1, 4'd9,  4'd6,  3'b011, 4'b1111, 0, 0, 0);
      drive(1, 1, 4'd3,  4'd5,  3'b000, 4'b0000, 0, 0, 0);
      drive(0, 1, 4'd3,  4'd5,  3'b000, 4'b1000, 0, 0, 1);
      drive(0, 0, 4'd0,  4'd0,  3'b000, 4'b0000, 0, 0, 0);

      begin
         int budget;
         budget = 0;
         while (q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
         end
         if (q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain_timeout: got %0d entries left in scoreboard, expected 0", q.size());
         end
      end
      @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
